sound_sequencer: RTL and testbench
==================================

// Module: sound_sequencer
// PURPOSE
//  Shares the single square-wave audio output among three game sound events: jump, level-clear and death.
//  Each event plays a fixed note sequence from an internal table. The block arbitrates between events,
//  sequences the notes and gaps, and generates the tone. It sits between game-state logic and the audio pin.
// PARAMETERS
//  NOTE_TICKS  3_146_875  clk cycles per note (~125 ms @ 25.175 MHz); 22-bit counter
//  GAP_TICKS   251_750    silent clk cycles between notes (~10 ms); 0 = no gap state
//  HP_SHIFT    0          right-shift applied to every table half-period (sim speed-up only)
// PORTS
//  clk          in   1  system pixel clock
//  reset        in   1  synchronous, active-high
//  jump_req     in   1  level; rising edge requests sound 0 (jump)
//  level_req    in   1  level; rising edge requests sound 1 (level clear)
//  death_req    in   1  level; rising edge requests sound 2 (death)
//  audio_out    out  1  square-wave output, 0 when silent
//  busy         out  1  1 while in PLAY or GAP
//  active_id    out  2  sound being played: 0 jump, 1 level, 2 death, 3 none
// BEHAVIOUR
//  Reset values: audio_out=0, busy=0, active_id=3, state=IDLE, all counters 0, edge registers 0.
//  Edge detect: a prev_* register per input. A request is req & ~prev_req, sampled on every clk.
//  Priority: death > level > jump. On simultaneous edges, only the highest wins. The others are dropped.
//  Note table, half-period in clk cycles (before >>HP_SHIFT), 17-bit:
//   jump : 28523, 21400                   (2 notes)
//   level: 47994, 38093, 32040, 23997     (4 notes, ascending)
//   death: 32040, 40380, 53880, 71920     (4 notes, descending)
//  FSM states: IDLE, PLAY, GAP.
//   IDLE -> PLAY on a winning edge:
//    active_id=winner, note_idx=0, dur_cnt=0, hp_cnt=0, audio_out=1.
//    Latency: the edge is sampled at cycle N. busy and audio_out are 1 from cycle N+1.
//   PLAY: hp_cnt counts. When it reaches half_period-1, audio_out toggles and hp_cnt goes to 0.
//    dur_cnt counts to NOTE_TICKS-1. At that cycle:
//     if more notes remain: -> GAP (or straight to PLAY on the next note if GAP_TICKS=0).
//     else: -> IDLE, with audio_out=0, busy=0, active_id=3.
//   GAP: audio_out=0 for GAP_TICKS cycles. Then -> PLAY, note_idx+1, counters 0, audio_out=1.
//  Preemption in PLAY or GAP:
//   higher-priority edge: restarts at note 0 of the new sound the next cycle, same as the IDLE entry.
//   same-id edge: restarts that sound at note 0.
//   lower-priority edge: ignored, not queued.
//  A request edge on the cycle a sound ends is handled as an IDLE entry on the following cycle. It is never lost.
//  Held-high inputs do not retrigger. A new rising edge is required.
//  Half-period after shift: if less than 1, it is clamped to 1.
//  reset asserted mid-sound: all outputs return to reset values on the next clk edge.
//  Counters never wrap. They are always cleared on terminal count.
// TESTING
//  (sim params NOTE_TICKS=64, GAP_TICKS=8, HP_SHIFT=12)
//  1. Pulse jump_req once.
//     -> busy=1 next cycle, active_id=0.
//     -> note 0 half-period 6 (28523>>12), note 1 half-period 5.
//     -> 8-cycle silent gap between the notes.
//     -> busy=0 and active_id=3 after 64+8+64 cycles.
//  2. Assert jump_req and death_req on the same cycle.
//     -> active_id=2.
//     -> 4 notes with half-periods 7, 9, 13, 17.
//     -> no jump sound afterwards.
//  3. Start the level sound, then pulse jump_req during note 2.
//     -> ignored, level plays to completion.
//     Then pulse death_req mid-note.
//     -> next cycle active_id=2, note_idx=0.
//  4. Hold jump_req high for 500 cycles.
//     -> exactly one jump sequence.
//     Pulse jump_req again during note 1.
//     -> restarts at note 0.
//  5. Assert reset during a death note while audio_out=1.
//     -> next cycle audio_out=0, busy=0, active_id=3.
//     -> a later edge starts normally.
//  6. Pulse level_req on the final cycle of a jump sound.
//     -> the level sound starts on the next cycle with no idle gap beyond 1 cycle.

Source files
------------

// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates jump/level/death sound events onto one square-wave pin.
// Latency: request edge -> tone next cycle; no backpressure, lower-priority edges during play are dropped.
module sound_sequencer #(
    parameter int unsigned NOTE_TICKS = 3_146_875,
    parameter int unsigned GAP_TICKS  = 251_750,
    parameter int unsigned HP_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump_req,
    input  logic       level_req,
    input  logic       death_req,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] active_id
);

    localparam int DW = 22;
    localparam int HW = 17;
    localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_TICKS - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     id_q, id_d;
    logic [1:0]     note_q, note_d;
    logic [DW-1:0]  dur_q, dur_d;
    logic [HW-1:0]  hp_q, hp_d;
    logic           audio_q, audio_d;
    logic [2:0]     prev_q;

    logic [2:0]     req_edge;
    logic           any_edge;
    logic [1:0]     win_id;
    logic [1:0]     last_note;
    logic [HW-1:0]  hp_limit;
    logic           start;

    function automatic logic [HW-1:0] half_period(input logic [1:0] id, input logic [1:0] idx);
        logic [HW-1:0] raw;
        logic [HW-1:0] sh;
        case ({id, idx})
            4'b00_00: raw = 17'd28523;
            4'b00_01: raw = 17'd21400;
            4'b01_00: raw = 17'd47994;
            4'b01_01: raw = 17'd38093;
            4'b01_10: raw = 17'd32040;
            4'b01_11: raw = 17'd23997;
            4'b10_00: raw = 17'd32040;
            4'b10_01: raw = 17'd40380;
            4'b10_10: raw = 17'd53880;
            4'b10_11: raw = 17'd71920;
            default:  raw = 17'd0;
        endcase
        sh = raw >> HP_SHIFT;
        if (sh == '0) begin
            sh = 17'd1;
        end
        return sh;
    endfunction

    // Bit order {death, level, jump}; ids equal priority rank, so a numeric compare decides preemption.
    assign req_edge  = {death_req, level_req, jump_req} & ~prev_q;
    assign any_edge  = |req_edge;
    assign win_id    = req_edge[2] ? 2'd2 : (req_edge[1] ? 2'd1 : 2'd0);
    assign last_note = (id_q == 2'd0) ? 2'd1 : 2'd3;
    assign hp_limit  = half_period(id_q, note_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            id_q    <= 2'd3;
            note_q  <= '0;
            dur_q   <= '0;
            hp_q    <= '0;
            audio_q <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            hp_q    <= hp_d;
            audio_q <= audio_d;
            prev_q  <= {death_req, level_req, jump_req};
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        note_d  = note_q;
        dur_d   = dur_q;
        hp_d    = hp_q;
        audio_d = audio_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                start = any_edge;
            end
            S_PLAY: begin
                if (any_edge && (win_id >= id_q)) begin
                    start = 1'b1;
                end else begin
                    if (hp_q == hp_limit - 17'd1) begin
                        hp_d    = '0;
                        audio_d = ~audio_q;
                    end else begin
                        hp_d = hp_q + 17'd1;
                    end
                    if (dur_q == NOTE_LAST) begin
                        dur_d = '0;
                        hp_d  = '0;
                        if (note_q != last_note) begin
                            if (GAP_TICKS == 0) begin
                                note_d  = note_q + 2'd1;
                                audio_d = 1'b1;
                            end else begin
                                state_d = S_GAP;
                                audio_d = 1'b0;
                            end
                        // Any edge on the final cycle starts the next sound directly so it is never lost.
                        end else if (any_edge) begin
                            start = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            audio_d = 1'b0;
                            id_d    = 2'd3;
                            note_d  = '0;
                        end
                    end else begin
                        dur_d = dur_q + 22'd1;
                    end
                end
            end
            S_GAP: begin
                if (any_edge && (win_id >= id_q)) begin
                    start = 1'b1;
                end else if (dur_q == GAP_LAST) begin
                    state_d = S_PLAY;
                    note_d  = note_q + 2'd1;
                    dur_d   = '0;
                    hp_d    = '0;
                    audio_d = 1'b1;
                end else begin
                    dur_d = dur_q + 22'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start) begin
            state_d = S_PLAY;
            id_d    = win_id;
            note_d  = '0;
            dur_d   = '0;
            hp_d    = '0;
            audio_d = 1'b1;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        audio_out = audio_q;
        active_id = id_q;
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: expected output runs (busy/id/audio held for N cycles) are queued at
// stimulus time; a negedge monitor collapses the DUT outputs into runs and checks them in order.
module tb_sound_sequencer;

    localparam int NT = 64;
    localparam int GT = 8;
    localparam int HS = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       jump_req, level_req, death_req;
    logic       audio_out, busy;
    logic [1:0] active_id;

    always #5 clk = ~clk;

    sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .HP_SHIFT(HS)) dut (
        .clk       (clk),
        .reset     (reset),
        .jump_req  (jump_req),
        .level_req (level_req),
        .death_req (death_req),
        .audio_out (audio_out),
        .busy      (busy),
        .active_id (active_id)
    );

    typedef struct packed {
        logic       busy;
        logic [1:0] id;
        logic       audio;
    } trip_t;

    typedef struct {
        trip_t t;
        int    len;
    } run_t;

    localparam trip_t IDLE_T = '{busy: 1'b0, id: 2'd3, audio: 1'b0};

    run_t  sb_q[$];
    int    ntests = 0;
    int    nfail  = 0;

    trip_t acc_t;
    int    acc_len  = 0;
    bit    acc_have = 1'b0;

    trip_t mon_t, cur_t;
    int    cur_len  = 0;
    bit    cur_have = 1'b0;
    bit    mon_en   = 1'b0;

    // Hand-computed half-periods: table value >> 12.
    function automatic int hp_of(input int id, input int n);
        case (id)
            0:       return (n == 0) ? 6 : 5;
            1:       case (n) 0: return 11; 1: return 9; 2: return 7; default: return 5; endcase
            default: case (n) 0: return 7; 1: return 9; 2: return 13; default: return 17; endcase
        endcase
    endfunction

    function automatic int full_len(input int id);
        return (id == 0) ? (2*NT + GT) : (4*NT + 3*GT);
    endfunction

    task automatic flush_acc();
        run_t r;
        r.t   = acc_t;
        r.len = (acc_t == IDLE_T) ? -1 : acc_len;
        sb_q.push_back(r);
        acc_have = 1'b0;
    endtask

    task automatic add_cycle(input trip_t t);
        if (acc_have && acc_t == t) begin
            acc_len++;
        end else begin
            if (acc_have) flush_acc();
            acc_t    = t;
            acc_len  = 1;
            acc_have = 1'b1;
        end
    endtask

    task automatic add_idle();
        add_cycle(IDLE_T);
    endtask

    // Expected outputs for the first n cycles of sound id, starting at note 0.
    task automatic build(input int id, input int n);
        trip_t t;
        int note, off;
        for (int k = 0; k < n; k++) begin
            note    = k / (NT + GT);
            off     = k % (NT + GT);
            t.busy  = 1'b1;
            t.id    = 2'(id);
            t.audio = (off < NT) && (((off / hp_of(id, note)) % 2) == 0);
            add_cycle(t);
        end
    endtask

    task automatic check_run(input trip_t t, input int len);
        run_t e;
        ntests++;
        if (sb_q.size() == 0) begin
            nfail++;
            $display("FAIL sb_underflow: got busy/id/audio=%0d/%0d/%0d len=%0d, expected no further run",
                     t.busy, t.id, t.audio, len);
        end else begin
            e = sb_q.pop_front();
            if (e.t !== t || (e.len >= 0 && e.len != len)) begin
                nfail++;
                $display("FAIL run: got busy/id/audio=%0d/%0d/%0d len=%0d, expected %0d/%0d/%0d len=%0d",
                         t.busy, t.id, t.audio, len, e.t.busy, e.t.id, e.t.audio, e.len);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_t = {busy, active_id, audio_out};
            if (cur_have && mon_t == cur_t) begin
                cur_len++;
            end else begin
                if (cur_have) check_run(cur_t, cur_len);
                cur_t    = mon_t;
                cur_len  = 1;
                cur_have = 1'b1;
            end
        end
    end

    task automatic drv(input bit j, input bit l, input bit d);
        jump_req  = j;
        level_req = l;
        death_req = d;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0);
        cyc(3);
        chk("reset_audio", int'(audio_out), 0);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_id",    int'(active_id), 3);
        reset = 1'b0;
        cyc(1);
        add_idle();
        mon_en = 1'b1;

        // 1: single jump pulse
        build(0, full_len(0)); add_idle();
        drv(1, 0, 0); cyc(1);
        chk("jump_busy_next", int'(busy), 1);
        chk("jump_id_next", int'(active_id), 0);
        drv(0, 0, 0); cyc(150);

        // 2: jump and death together, death wins, jump dropped
        build(2, full_len(2)); add_idle();
        drv(1, 0, 1); cyc(1); drv(0, 0, 0); cyc(300);

        // 3a: level, jump pulse during note 2 ignored
        build(1, full_len(1)); add_idle();
        drv(0, 1, 0); cyc(1); drv(0, 0, 0); cyc(159);
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(150);

        // 3b: level preempted by death mid-note 1
        build(1, 100); build(2, full_len(2)); add_idle();
        drv(0, 1, 0); cyc(1); drv(0, 0, 0); cyc(99);
        drv(0, 0, 1); cyc(1);
        chk("preempt_id", int'(active_id), 2);
        drv(0, 0, 0); cyc(300);

        // 4: held jump plays once; later re-pulse in note 1 restarts
        build(0, full_len(0)); add_idle();
        build(0, 82); build(0, full_len(0)); add_idle();
        drv(1, 0, 0); cyc(500); drv(0, 0, 0); cyc(5);
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(81);
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(150);

        // 5: reset during a death note with audio high, then a normal start
        build(2, 150); add_idle();
        drv(0, 0, 1); cyc(1); drv(0, 0, 0); cyc(149);
        chk("pre_reset_audio", int'(audio_out), 1);
        reset = 1'b1; cyc(1);
        chk("mid_reset_audio", int'(audio_out), 0);
        chk("mid_reset_busy",  int'(busy), 0);
        chk("mid_reset_id",    int'(active_id), 3);
        reset = 1'b0; cyc(10);
        build(0, full_len(0)); add_idle();
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(150);

        // 6: level edge on final jump cycle chains directly
        build(0, full_len(0)); build(1, full_len(1)); add_idle();
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(135);
        drv(0, 1, 0); cyc(1); drv(0, 0, 0); cyc(300);

        // 6b: lower-priority jump edge on final death cycle is not lost
        build(2, full_len(2)); build(0, full_len(0)); add_idle();
        drv(0, 0, 1); cyc(1); drv(0, 0, 0); cyc(279);
        drv(1, 0, 0); cyc(1); drv(0, 0, 0); cyc(150);

        cyc(5);
        flush_acc();
        mon_en = 1'b0;
        #1;
        if (cur_have) check_run(cur_t, cur_len);
        chk("sb_leftover", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
